regfile_mp: RTL and testbench

- Parametrised successor to the pipeline integer register file.
- Provides NUM_RD combinational read ports, one write port, and x0 hardwired to zero.
- Optional write-to-read bypass removes the WB→ID forwarding path from the hazard unit.
- Replaces the old combinational "force-zero" clear with a multi-cycle hardware clear sequencer (busy/done handshake), used by the core on context flush.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_clr_seq.sv | 38 +++
 rtl/regfile_mp.sv | 59 +++++
 tb/tb_regfile_mp.sv | 136 +++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types, defaults and helpers for the multi-port register file.
package regfile_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_REGS_DEF = 32;
    typedef enum logic {IDLE, CLEAR} clr_state_e;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_clr_seq.sv
// regfile_clr_seq: multi-cycle clear sequencer producing busy/done and a per-register clear mask.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int CLR_PER_CYCLE = 8,
    localparam int PW = clog2(NUM_REGS) + 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done,
    output logic [NUM_REGS-1:0] clr_mask
);
    clr_state_e state_q, state_d;
    logic [PW-1:0] clr_ptr_q, clr_ptr_d;
    logic last;
    always_comb begin
        last = clr_ptr_q == PW'(NUM_REGS - CLR_PER_CYCLE);
        clr_busy = state_q == CLEAR;
        clr_done = clr_busy && last;
        state_d = clr_busy ? (last ? IDLE : CLEAR) : (clr_req ? CLEAR : IDLE);
        clr_ptr_d = clr_busy ? clr_ptr_q + PW'(CLR_PER_CYCLE) : '0;
        // clr_ptr is one bit wider than an address so the final increment does not wrap
        for (int r = 0; r < NUM_REGS; r++)
            clr_mask[r] = clr_busy && PW'(r) >= clr_ptr_q && PW'(r) < clr_ptr_q + PW'(CLR_PER_CYCLE);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            clr_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised register file with NUM_RD read ports, one write port,
// x0 hardwired to zero, optional write bypass and a hardware clear sequencer.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1,
    parameter int CLR_PER_CYCLE = 8,
    localparam int AW = clog2(NUM_REGS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     wren,
    input  logic [AW-1:0]            rd_addr,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*DATA_W-1:0] rs_data,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done,
    output logic                     wr_drop
);
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] clr_mask;
    logic wr_en;

    regfile_clr_seq #(.NUM_REGS(NUM_REGS), .CLR_PER_CYCLE(CLR_PER_CYCLE)) u_clr_seq (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .clr_req (clr_req),
        .clr_busy(clr_busy),
        .clr_done(clr_done),
        .clr_mask(clr_mask)
    );

    assign wr_en = wren && rd_addr != '0;
    assign wr_drop = wr_en && clr_busy;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++)
            regs_d[r] = clr_mask[r] ? '0 : (wr_en && !clr_busy && rd_addr == AW'(r)) ? rd_data : regs_q[r];
    end

    always_ff @(posedge i_clk) begin
        for (int r = 0; r < NUM_REGS; r++)
            regs_q[r] <= i_rst ? '0 : regs_d[r];
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = rs_addr[i*AW +: AW];
        // reads of x0 and reads during a clear are forced to zero ahead of the bypass
        assign rs_data[i*DATA_W +: DATA_W] = (ra == '0 || clr_busy) ? '0 :
            (BYPASS != 0 && wren && rd_addr == ra) ? rd_data : regs_q[ra];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench driving a bypassed and an unbypassed regfile_mp in lockstep.
module tb_regfile_mp;
    localparam int DW = 32, NR = 32, AW = 5, NRD = 2, CPC = 8, CC = NR / CPC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic i_rst, wren, clr_req;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [NRD*AW-1:0] rs_addr;
    logic [NRD*DW-1:0] rs_b, rs_n;
    logic busy_b, busy_n, done_b, done_n, drop_b, drop_n;

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(1), .CLR_PER_CYCLE(CPC)) u_byp (
        .i_clk(clk), .i_rst(i_rst), .wren(wren), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs_addr(rs_addr), .rs_data(rs_b), .clr_req(clr_req), .clr_busy(busy_b),
        .clr_done(done_b), .wr_drop(drop_b));

    regfile_mp #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD), .BYPASS(0), .CLR_PER_CYCLE(CPC)) u_nob (
        .i_clk(clk), .i_rst(i_rst), .wren(wren), .rd_addr(rd_addr), .rd_data(rd_data),
        .rs_addr(rs_addr), .rs_data(rs_n), .clr_req(clr_req), .clr_busy(busy_n),
        .clr_done(done_n), .wr_drop(drop_n));

    typedef struct {
        logic busy, done, drop;
        logic [NRD*DW-1:0] rs_b, rs_n;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    logic [DW-1:0] mem [NR];
    int clr_left = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("rs_data_bypass", 64'(rs_b), 64'(e.rs_b));
            chk("rs_data_nobypass", 64'(rs_n), 64'(e.rs_n));
            chk("clr_busy", 64'({busy_b, busy_n}), 64'({e.busy, e.busy}));
            chk("clr_done", 64'({done_b, done_n}), 64'({e.done, e.done}));
            chk("wr_drop", 64'({drop_b, drop_n}), 64'({e.drop, e.drop}));
        end
    end

    // Model: a clear wipes every register at once; reads are zero for the CC busy cycles anyway.
    task automatic cycle(input logic rst, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic req, input bit push = 1);
        exp_t e;
        logic busy;
        logic [AW-1:0] a;
        i_rst = rst; wren = we; rd_addr = wa; rd_data = wd; rs_addr = {a1, a0}; clr_req = req;
        busy = clr_left > 0;
        e.busy = busy;
        e.done = clr_left == 1;
        e.drop = we && wa != 0 && busy;
        for (int p = 0; p < NRD; p++) begin
            a = (p == 0) ? a0 : a1;
            e.rs_n[p*DW +: DW] = (a == 0 || busy) ? '0 : mem[a];
            e.rs_b[p*DW +: DW] = (a == 0 || busy) ? '0 : (we && wa == a) ? wd : mem[a];
        end
        if (push) q.push_back(e);
        if (rst) begin
            for (int r = 0; r < NR; r++) mem[r] = '0;
            clr_left = 0;
        end else if (busy) begin
            clr_left--;
        end else begin
            if (we && wa != 0) mem[wa] = wd;
            if (req) begin
                for (int r = 0; r < NR; r++) mem[r] = '0;
                clr_left = CC;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < NR; r++) mem[r] = '0;
        i_rst = 1; wren = 0; rd_addr = '0; rd_data = '0; rs_addr = '0; clr_req = 0;
        @(posedge clk);
        #1;
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i < NR; i++) cycle(0, 0, 0, 0, AW'(i), AW'(NR - i), 0);

        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
        cycle(0, 1, 0, 32'h12345678, 5, 0, 0);
        cycle(0, 0, 0, 0, 5, 0, 0);

        cycle(0, 1, 7, 32'hA5A5A5A5, 7, 5, 0);
        cycle(0, 0, 0, 0, 7, 7, 0);

        for (int i = 1; i < NR; i++) cycle(0, 1, AW'(i), DW'(i), AW'(i), AW'(i - 1), 0);
        for (int i = 1; i < NR; i += 2) cycle(0, 0, 0, 0, AW'(i), AW'(i + 1), 0);
        cycle(0, 0, 0, 0, 9, 10, 1);
        for (int i = 0; i < CC; i++) cycle(0, 0, 0, 0, AW'(i + 1), AW'(i + 20), 0);
        for (int i = 1; i < NR; i += 2) cycle(0, 0, 0, 0, AW'(i), AW'(i + 1), 0);

        cycle(0, 1, 3, 32'h22, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 0, 1);
        cycle(0, 0, 0, 0, 3, 0, 0);
        cycle(0, 1, 3, 32'h11, 3, 3, 1);
        cycle(0, 0, 0, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 0, 0);
        cycle(0, 0, 0, 0, 3, 3, 0);
        cycle(0, 0, 0, 0, 3, 3, 0);

        cycle(0, 1, 12, 32'h0BADF00D, 12, 0, 0);
        cycle(0, 0, 0, 0, 12, 0, 1);
        cycle(0, 0, 0, 0, 12, 0, 0);
        cycle(1, 0, 0, 0, 12, 0, 0);
        cycle(0, 0, 0, 0, 12, 1, 0);
        cycle(0, 1, 12, 32'h77, 12, 0, 0);
        cycle(0, 0, 0, 0, 12, 0, 1);
        for (int i = 0; i < CC + 2; i++) cycle(0, 0, 0, 0, 12, 0, 0);

        for (int n = 0; n < 600; n++)
            cycle(($urandom_range(63) == 0), $urandom_range(1), AW'($urandom), $urandom,
                  AW'($urandom), AW'($urandom), ($urandom_range(15) == 0));

        repeat (2) @(posedge clk);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
